// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: multi-cycle MULT/MULTU/DIV/DIVU with
// architectural HI/LO, MFHI/MFLO/MTHI/MTLO access and a busy/stall output
// for the hazard unit.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MDU_src1,
    input  logic [31:0] MDU_src2,
    input  logic [3:0]  MDU_op,
    input  logic        MDU_start,
    output logic        E_MDU_busy,
    output logic        E_MDU_stall,
    output logic [31:0] E_MDU_result
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      hi, hi_nxt;
    logic [31:0]      lo, lo_nxt;
    logic [31:0]      temp_hi, temp_hi_nxt;
    logic [31:0]      temp_lo, temp_lo_nxt;
    logic             div_zero, div_zero_nxt;

    logic        is_muldiv;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, divisor;
    logic [31:0] quo_u, rem_u, quo, rem;

    // Decode and datapath: product and quotient/remainder from E-stage operands
    always_comb begin
        is_muldiv = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU) ||
                    (MDU_op == OP_DIV)  || (MDU_op == OP_DIVU);
        is_div    = (MDU_op == OP_DIV)  || (MDU_op == OP_DIVU);
        prod_s    = $signed({{32{MDU_src1[31]}}, MDU_src1}) * $signed({{32{MDU_src2[31]}}, MDU_src2});
        prod_u    = {32'd0, MDU_src1} * {32'd0, MDU_src2};
        // Signed divide done on magnitudes: gives truncation toward zero,
        // remainder sign from the dividend, and 0x80000000 / -1 = 0x80000000
        // without relying on simulator overflow behaviour.
        neg_a     = (MDU_op == OP_DIV) && MDU_src1[31];
        neg_b     = (MDU_op == OP_DIV) && MDU_src2[31];
        mag_a     = neg_a ? (32'd0 - MDU_src1) : MDU_src1;
        mag_b     = neg_b ? (32'd0 - MDU_src2) : MDU_src2;
        divisor   = (mag_b == '0) ? 32'd1 : mag_b;
        quo_u     = mag_a / divisor;
        rem_u     = mag_a % divisor;
        quo       = (neg_a ^ neg_b) ? (32'd0 - quo_u) : quo_u;
        rem       = neg_a ? (32'd0 - rem_u) : rem_u;
    end

    // Next-state: accept start in IDLE, count down in RUN, commit on the last edge
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        hi_nxt       = hi;
        lo_nxt       = lo;
        temp_hi_nxt  = temp_hi;
        temp_lo_nxt  = temp_lo;
        div_zero_nxt = div_zero;
        case (state)
            S_IDLE: begin
                if (MDU_start && is_muldiv) begin
                    state_nxt    = S_RUN;
                    div_zero_nxt = is_div && (MDU_src2 == '0);
                    cnt_nxt      = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    case (MDU_op)
                        OP_MULT:  {temp_hi_nxt, temp_lo_nxt} = prod_s;
                        OP_MULTU: {temp_hi_nxt, temp_lo_nxt} = prod_u;
                        default: begin
                            temp_hi_nxt = rem;
                            temp_lo_nxt = quo;
                        end
                    endcase
                end else if (MDU_op == OP_MTHI) begin
                    hi_nxt = MDU_src1;
                end else if (MDU_op == OP_MTLO) begin
                    lo_nxt = MDU_src1;
                end
            end
            S_RUN: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                    if (!div_zero) begin
                        hi_nxt = temp_hi;
                        lo_nxt = temp_lo;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            temp_hi  <= '0;
            temp_lo  <= '0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            hi       <= hi_nxt;
            lo       <= lo_nxt;
            temp_hi  <= temp_hi_nxt;
            temp_lo  <= temp_lo_nxt;
            div_zero <= div_zero_nxt;
        end
    end

    // Outputs: busy from the state register, stall and read mux combinational
    always_comb begin
        E_MDU_busy  = (state == S_RUN);
        E_MDU_stall = E_MDU_busy || (MDU_start && is_muldiv);
        case (MDU_op)
            OP_MFHI: E_MDU_result = hi;
            OP_MFLO: E_MDU_result = lo;
            default: E_MDU_result = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu with hand-computed expected values.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] MDU_src1;
    logic [31:0] MDU_src2;
    logic [3:0]  MDU_op;
    logic        MDU_start;
    logic        E_MDU_busy;
    logic        E_MDU_stall;
    logic [31:0] E_MDU_result;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .MDU_src1     (MDU_src1),
        .MDU_src2     (MDU_src2),
        .MDU_op       (MDU_op),
        .MDU_start    (MDU_start),
        .E_MDU_busy   (E_MDU_busy),
        .E_MDU_stall  (E_MDU_stall),
        .E_MDU_result (E_MDU_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi_exp, input logic [31:0] lo_exp);
        MDU_op = 4'd5;
        #1 check({tag, " HI"}, E_MDU_result, hi_exp);
        MDU_op = 4'd6;
        #1 check({tag, " LO"}, E_MDU_result, lo_exp);
        MDU_op = 4'd0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] val);
        MDU_op   = op;
        MDU_src1 = val;
        tick();
        MDU_op   = 4'd0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int unsigned n);
        int unsigned busy_cnt;
        int unsigned stall_cnt;
        MDU_op    = op;
        MDU_src1  = a;
        MDU_src2  = b;
        MDU_start = 1'b1;
        #1;
        check({tag, " stall@start"}, 32'(E_MDU_stall), 32'd1);
        check({tag, " busy@start"}, 32'(E_MDU_busy), 32'd0);
        tick();
        MDU_start = 1'b0;
        MDU_op    = 4'd0;
        busy_cnt  = 0;
        stall_cnt = 1;
        for (int i = 0; i < 40 && E_MDU_busy; i++) begin
            busy_cnt++;
            if (E_MDU_stall) stall_cnt++;
            tick();
        end
        check({tag, " busy cycles"}, busy_cnt, n);
        check({tag, " stall cycles"}, stall_cnt, n + 1);
    endtask

    initial begin
        reset     = 1'b1;
        MDU_src1  = '0;
        MDU_src2  = '0;
        MDU_op    = 4'd0;
        MDU_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 32'(E_MDU_busy), 32'd0);
        check("reset stall", 32'(E_MDU_stall), 32'd0);
        reset = 1'b0;
        tick();
        read_hilo("after reset", 32'h0, 32'h0);

        run_op("MULT", 4'd1, 32'hFFFFFFFE, 32'h00000003, 5);
        read_hilo("MULT", 32'hFFFFFFFF, 32'hFFFFFFFA);

        run_op("MULTU", 4'd2, 32'hFFFFFFFE, 32'h00000003, 5);
        read_hilo("MULTU", 32'h00000002, 32'hFFFFFFFA);

        run_op("DIV", 4'd3, 32'hFFFFFFF9, 32'h00000002, 10);
        read_hilo("DIV", 32'hFFFFFFFF, 32'hFFFFFFFD);

        run_op("DIVU", 4'd4, 32'h00000007, 32'h00000002, 10);
        read_hilo("DIVU", 32'h00000001, 32'h00000003);

        run_op("DIV ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        read_hilo("DIV ovf", 32'h00000000, 32'h80000000);

        move_to(4'd7, 32'h12345678);
        move_to(4'd8, 32'h9ABCDEF0);
        read_hilo("MTHI/MTLO", 32'h12345678, 32'h9ABCDEF0);
        MDU_op = 4'd9;
        #1 check("op9 result", E_MDU_result, 32'h0);
        MDU_op = 4'd0;
        #1 check("nop result", E_MDU_result, 32'h0);
        run_op("DIVU by 0", 4'd4, 32'h00000005, 32'h00000000, 10);
        read_hilo("DIVU by 0", 32'h12345678, 32'h9ABCDEF0);

        // Activity during a MULT in flight must not disturb HI/LO or the operation
        MDU_op    = 4'd1;
        MDU_src1  = 32'd3;
        MDU_src2  = 32'd4;
        MDU_start = 1'b1;
        tick();
        MDU_start = 1'b0;
        MDU_op    = 4'd6;
        #1 check("run MFLO 1", E_MDU_result, 32'h9ABCDEF0);
        check("run busy", 32'(E_MDU_busy), 32'd1);
        tick();
        MDU_op   = 4'd8;
        MDU_src1 = 32'hDEADBEEF;
        tick();
        MDU_op = 4'd6;
        #1 check("run MFLO 2", E_MDU_result, 32'h9ABCDEF0);
        tick();
        MDU_op    = 4'd1;
        MDU_src1  = 32'd7;
        MDU_src2  = 32'd7;
        MDU_start = 1'b1;
        #1 check("run 2nd start stall", 32'(E_MDU_stall), 32'd1);
        tick();
        MDU_start = 1'b0;
        MDU_op    = 4'd0;
        check("run busy last", 32'(E_MDU_busy), 32'd1);
        tick();
        check("run done busy", 32'(E_MDU_busy), 32'd0);
        tick();
        check("run no restart", 32'(E_MDU_busy), 32'd0);
        read_hilo("run final", 32'h00000000, 32'h0000000C);

        run_op("b2b MULT", 4'd1, 32'd2, 32'd3, 5);
        run_op("b2b DIV", 4'd3, 32'd100, 32'd7, 10);
        read_hilo("b2b", 32'h00000002, 32'h0000000E);

        // Asynchronous reset in the middle of a MULT
        MDU_op    = 4'd1;
        MDU_src1  = 32'd6;
        MDU_src2  = 32'd7;
        MDU_start = 1'b1;
        tick();
        MDU_start = 1'b0;
        MDU_op    = 4'd0;
        tick();
        check("pre-reset busy", 32'(E_MDU_busy), 32'd1);
        #1 reset = 1'b1;
        #1 check("mid-run reset busy", 32'(E_MDU_busy), 32'd0);
        reset = 1'b0;
        tick();
        read_hilo("mid-run reset", 32'h0, 32'h0);
        repeat (6) tick();
        check("post-reset busy", 32'(E_MDU_busy), 32'd0);
        read_hilo("post-reset", 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the pipelined MIPS core, the multi-cycle companion of the single-cycle ALU. It takes the same two E-stage operands, runs MULT/MULTU/DIV/DIVU over a fixed number of cycles, holds the products and quotients in architectural HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO. It exports a busy/stall indication that the hazard unit uses to freeze D/E while an operation is in flight.

## Interface
- MULT_CYCLES, 5: busy cycles for MULT/MULTU.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- MDU_src1  in  32  operand rs (E stage).
- MDU_src2  in  32  operand rt (E stage).
- MDU_op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as NOP.
- MDU_start  in  1  qualifies MDU_op for ops 1–4 (E-stage instruction is valid and not flushed).
- E_MDU_busy  out  1  registered; high while an operation is in flight.
- E_MDU_stall  out  1  combinational: E_MDU_busy | (MDU_start & op∈{1..4}).
- E_MDU_result  out  32  combinational: HI for MFHI, LO for MFLO, else 0.

## Operation
- State: HI[31:0], LO[31:0], temp_hi/temp_lo[31:0], busy, cnt[3:0] (width ≥ clog2(max(MULT_CYCLES, DIV_CYCLES)+1)).
- Two states: IDLE (busy=0), RUN (busy=1).
- IDLE + MDU_start + op∈{1..4}: compute result at this edge into temp_hi/temp_lo, load cnt = MULT_CYCLES or DIV_CYCLES, go RUN.
  - MULT: {temp_hi,temp_lo} = signed(src1)·signed(src2), 64-bit.
  - MULTU: unsigned 64-bit product.
  - DIV: temp_lo = signed quotient truncated toward zero, temp_hi = remainder with sign of dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV with 0x80000000 / 0xFFFFFFFF: temp_lo = 0x80000000, temp_hi = 0.
  - Divide by zero (DIV/DIVU, src2 = 0): operation still occupies DIV_CYCLES, HI/LO left unchanged at commit.
- RUN: cnt decrements every edge; on the edge where cnt goes 1→0, HI/LO ← temp (unless divide-by-zero) and busy ← 0.
- MTHI/MTLO: HI or LO ← MDU_src1 at the edge, only in IDLE; ignored in RUN. Not qualified by MDU_start.
- MDU_start with op∈{1..4} while in RUN: ignored (hazard unit guarantees this does not occur; must not corrupt state).
- MFHI/MFLO read committed HI/LO; values in flight are never visible.
- Ops 0, 9–15: no state change, E_MDU_result = 0.

## Timing
- Reset (async, any time, including mid-RUN): HI=0, LO=0, temp=0, busy=0, cnt=0, state IDLE; in-flight result discarded. Outputs after reset: E_MDU_busy=0, E_MDU_stall=0 unless start/op driven, E_MDU_result=0 unless MFHI/MFLO selected.
- Start accepted at edge T0 → E_MDU_busy high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), low again after edge T0+N; HI/LO show new value from edge T0+N onward.
- E_MDU_stall is high in the start cycle itself (combinational) and for all N busy cycles: N+1 stall cycles total.
- Back-to-back: new start is accepted in the first cycle busy=0 (edge T0+N+1 at earliest).
- MTHI/MTLO latency: 1 edge; an MFHI/MFLO in the following cycle sees the new value.
- E_MDU_result has no registered latency; it changes only on HI/LO update edges or MDU_op changes.

## Test plan
- Reset then MFHI/MFLO → 0/0; E_MDU_busy=0. Assert reset during RUN of a MULT → busy drops immediately, HI=LO=0 afterward.
- MULT 0xFFFFFFFE × 0x00000003 → busy for 5 cycles, stall for 6, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (−7) / 2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 → LO=3, HI=1; DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x12345678, MTLO 0x9ABCDEF0, then DIVU x/0 → busy 10 cycles, HI/LO remain 0x12345678/0x9ABCDEF0.
- During MULT RUN: MFLO returns old LO every cycle; MTLO 0xDEADBEEF and a second MULT start are ignored; final LO equals first product.
- Back-to-back MULT then DIV: second start in cycle busy first falls → accepted, busy continuous-but-gap of one idle cycle, final HI/LO from DIV.
